// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the serial sequence detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_detect_pkg;

    // Default maximum pattern length in bits.
    localparam int DEF_MAX_LEN = 8;
    // Default width of the match counter and the match target.
    localparam int DEF_CNT_W   = 8;

    // Controller states.
    //   ST_IDLE  : waiting for a configuration, cfg_ready high
    //   ST_ARMED : configuration latched, waiting for start
    //   ST_RUN   : consuming serial bits and counting matches
    //   ST_DONE  : target reached, serial input ignored until start/clear
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_match_shifter.sv
// History shift register, bits-seen counter and pattern compare.
// Latency: match is combinational on the shifted-in bit; state updates on the next clc edge.
// Backpressure: none; shift is a plain qualifier and the block holds state while it is low.
//
// Ports:
//   clc, rst       clock, synchronous active-high reset
//   clr            synchronous clear of history and bits-seen (config untouched)
//   shift, a       shift-enable qualifier and the serial bit to shift in
//   pattern, len   latched pattern (bit 0 = last bit received) and its length
//   match          high when the bit being shifted in completes a match
module seq_match_shifter
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clc,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift,
    input  logic               a,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   seen;
    logic [LEN_W-1:0]   seen_nxt;

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len)) begin
                len_mask[i] = 1'b1;
            end
        end
    end

    // Newest bit enters at bit 0. Written as shift-then-overwrite so the
    // expression stays legal when MAX_LEN is 1.
    always_comb begin
        hist_nxt    = hist << 1;
        hist_nxt[0] = a;
    end

    // bits-seen only needs to tell "fewer than len" from "at least len",
    // so it parks at len instead of wrapping.
    assign seen_nxt = (seen >= len) ? seen : seen + LEN_W'(1);

    // The compare looks at the post-shift view so the current bit counts.
    assign match = shift
                && (seen_nxt >= len)
                && (((hist_nxt ^ pattern) & len_mask) == '0);

    always_ff @(posedge clc) begin
        if (rst || clr) begin
            hist <= '0;
            seen <= '0;
        end else if (shift) begin
            hist <= hist_nxt;
            seen <= seen_nxt;
        end
    end

endmodule

// File: rtl/seq_detect_controller.sv
// Serial pattern detector with configurable pattern/length/target and a run-control FSM.
// Latency: detected pulses one cycle after the a_valid cycle that completes a match.
// Backpressure: cfg_ready is high only in IDLE; serial bits have no backpressure (a_valid only).
//
// Ports:
//   clc, rst                       clock, synchronous active-high reset
//   cfg_valid/cfg_ready            configuration handshake (pattern, len, target)
//   cfg_err                        one-cycle pulse when an offered length is illegal
//   start, stop, clear             control strobes
//   a, a_valid                     serial data bit and its qualifier
//   detected                       registered match pulse
//   busy, done                     state is RUN / state is DONE
//   match_count                    matches since last start, saturating
module seq_detect_controller
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                         clc,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]             cfg_target,
    output logic                         cfg_err,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         clear,
    input  logic                         a,
    input  logic                         a_valid,
    output logic                         detected,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             match_count
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    state_t             state;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   tgt_q;

    logic               cfg_legal;
    logic               restart;
    logic               shift;
    logic               match;
    logic [CNT_W-1:0]   cnt_inc;
    logic               tgt_hit;

    assign cfg_legal = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);

    // start is honoured only from ARMED or DONE; clear overrides it.
    assign restart = !clear && start && ((state == ST_ARMED) || (state == ST_DONE));

    // Bits are consumed only while running; clear blocks the shift so a
    // clear cycle never produces a match.
    assign shift = !clear && a_valid && (state == ST_RUN);

    assign cnt_inc = (match_count == '1) ? match_count : match_count + CNT_W'(1);
    assign tgt_hit = (tgt_q != '0) && (cnt_inc == tgt_q);

    // Status outputs are pure decodes of the state register.
    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);

    seq_match_shifter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shifter (
        .clc     (clc),
        .rst     (rst),
        .clr     (clear || restart),
        .shift   (shift),
        .a       (a),
        .pattern (pat_q),
        .len     (len_q),
        .match   (match)
    );

    always_ff @(posedge clc) begin
        if (rst) begin
            state       <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            tgt_q       <= '0;
            match_count <= '0;
            detected    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            detected <= 1'b0;
            cfg_err  <= 1'b0;
            if (clear) begin
                // Configuration is deliberately kept so software can re-arm
                // by offering a new config or reusing the same one.
                state       <= ST_IDLE;
                match_count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cfg_valid) begin
                            if (cfg_legal) begin
                                pat_q <= cfg_pattern;
                                len_q <= cfg_len;
                                tgt_q <= cfg_target;
                                state <= ST_ARMED;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_ARMED: begin
                        // start beats a simultaneous stop; stop alone is a no-op here.
                        if (start) begin
                            state       <= ST_RUN;
                            match_count <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (match) begin
                            detected    <= 1'b1;
                            match_count <= cnt_inc;
                            // Reaching the target outranks a stop in the same cycle.
                            if (tgt_hit) begin
                                state <= ST_DONE;
                            end else if (stop) begin
                                state <= ST_ARMED;
                            end
                        end else if (stop) begin
                            state <= ST_ARMED;
                        end
                    end
                    ST_DONE: begin
                        if (start) begin
                            state       <= ST_RUN;
                            match_count <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/seq_detect_controller.md
SEQ_DETECT_CONTROLLER -- requirements
Module: seq_detect_controller

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8: maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 8: width of match counter and target.
REQ-003 SHALL have port clc  input  1  sole clock; all logic on posedge clc.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_valid  input  1  configuration offer.
REQ-006 SHALL have port cfg_ready  output  1  high only in IDLE; transfer when cfg_valid & cfg_ready.
REQ-007 SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit len-1 is first bit received, bit 0 last.
REQ-008 SHALL have port cfg_len  input  $clog2(MAX_LEN+1)  pattern length, legal 1..MAX_LEN.
REQ-009 SHALL have port cfg_target  input  CNT_W  matches before DONE; 0 = unlimited.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse on rejected configuration.
REQ-011 SHALL have port start / stop / clear  input  1 each  control strobes.
REQ-012 SHALL have port a  input  1  serial data bit; a_valid  input  1  bit qualifier.
REQ-013 SHALL have ports detected  output  1  match pulse; busy  output  1  state==RUN; done  output  1  state==DONE.
REQ-014 SHALL have port match_count  output  CNT_W  matches since last start, saturating at all-ones.

Function
REQ-015 States SHALL be IDLE, ARMED, RUN, DONE.
REQ-016 IDLE: accepted cfg with legal cfg_len latches pattern/len/target -> ARMED; illegal len (0 or >MAX_LEN) -> cfg_err pulse next cycle, remain IDLE, nothing latched.
REQ-017 ARMED: start -> RUN, clearing history, bits-seen counter and match_count in the same edge.
REQ-018 RUN: each a_valid cycle shifts a into history (newest at bit 0); bits-seen increments, saturating at len; a_valid low SHALL leave all state unchanged.
REQ-019 Match SHALL be declared when, including the current bit, bits-seen >= len and low len history bits equal low len pattern bits; overlapping matches SHALL all count.
REQ-020 detected SHALL be registered: high exactly the cycle after the a_valid cycle completing the match, otherwise low.
REQ-021 Each match SHALL increment match_count (saturating); when nonzero target equals new count, next state DONE.
REQ-022 RUN: stop -> ARMED, keeping match_count; a match in the stop cycle SHALL still pulse detected and count.
REQ-023 DONE: a/a_valid ignored; start -> RUN with clears per REQ-017; stop ignored.
REQ-024 clear in any state SHALL return to IDLE, zero match_count and history, keep latched configuration; clear has priority over start/stop/cfg.
REQ-025 start in IDLE or RUN SHALL be ignored; start and stop together in ARMED: start wins.

Reset
REQ-026 rst SHALL force IDLE; match_count, history, bits-seen, detected, cfg_err, busy, done = 0; pattern/len/target = 0; cfg_ready = 1 the cycle after rst deasserts.
REQ-027 rst mid-RUN SHALL suppress any pending detected pulse.

Structure
REQ-028 Package seq_detect_pkg SHALL hold the state enum typedef and default MAX_LEN/CNT_W constants.
REQ-029 History shift register, bits-seen counter and compare SHALL be sub-module seq_match_shifter; controller FSM and counter stay in the top.

Verification
REQ-030 Pattern 6'b110011, len 6, target 0; bits 1,1,0,0,1,1 -> detected one cycle after 6th bit, match_count=1.
REQ-031 Pattern 4'b1010, len 4; bits 1,0,1,0,1,0 -> detected after 4th and 6th bits, match_count=2.
REQ-032 Target 2 with REQ-031 stimulus -> done after 2nd match; further bits 1,0,1,0 -> no detected, count stays 2; start -> RUN, count 0.
REQ-033 cfg_len=0 and cfg_len=MAX_LEN+1 -> cfg_err pulse each, state IDLE, cfg_ready stays 1.
REQ-034 Pattern 110011: bits 1,1,0, stop, start, bits 0,1,1 -> no detection (history cleared); a_valid gaps between bits of a full pattern -> still detected.
REQ-035 rst asserted in cycle of matching last bit -> detected stays 0, all outputs reset, IDLE.
